// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: forwarding operand muxes, iterative shift-add
// multiply and restoring divide sharing one hi/lo register pair, with pipeline stall.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [1:0]      fwdA,
    input  logic [1:0]      fwdB,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            sa_q, sa_d, sb_q, sb_d;

    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
    logic            is_div, a_signed, b_signed, sa, sb, div_zero, ovf;

    always_comb begin
        unique case (fwdA)
            2'b01:   op_a = mem_fwd_data;
            2'b10:   op_a = wb_fwd_data;
            default: op_a = rs1_data;
        endcase
        unique case (fwdB)
            2'b01:   op_b = mem_fwd_data;
            2'b10:   op_b = wb_fwd_data;
            default: op_b = rs2_data;
        endcase
    end

    assign is_div   = funct3[2];
    assign a_signed = !(funct3[0] && (funct3[1] || funct3[2]));
    assign b_signed = funct3[2] ? !funct3[0] : !funct3[1];
    assign sa       = a_signed && op_a[XLEN-1];
    assign sb       = b_signed && op_b[XLEN-1];
    assign mag_a    = sa ? -op_a : op_a;
    assign mag_b    = sb ? -op_b : op_b;
    assign div_zero = is_div && (op_b == '0);
    assign ovf      = is_div && !funct3[0] && (op_a == SMIN) && (op_b == ONES);

    // One iteration step. Multiply: hi accumulates, lo holds multiplier and shifts
    // product bits in. Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [XLEN-1:0]   hi_n, lo_n, quo_s, rem_s, fin;
    logic [2*XLEN-1:0] prod, prod_s;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb_q};

    always_comb begin
        if (f3_q[2]) begin
            hi_n = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], !div_trial[XLEN]};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign prod   = {hi_n, lo_n};
    assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
    assign quo_s  = (sa_q ^ sb_q) ? -lo_n : lo_n;
    assign rem_s  = sa_q ? -hi_n : hi_n;

    always_comb begin
        unique case (f3_q)
            3'b000:         fin = prod_s[XLEN-1:0];
            3'b100, 3'b101: fin = quo_s;
            3'b110, 3'b111: fin = rem_s;
            default:        fin = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    sa_d  = sa;
                    sb_d  = sb;
                    hi_d  = '0;
                    cnt_d = CW'(XLEN);
                    lo_d  = is_div ? mag_a : mag_b;
                    opb_d = is_div ? mag_b : mag_a;
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : ONES;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = funct3[1] ? '0 : op_a;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = fin;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A killed op never updates the visible result.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
endmodule
